// File: rtl/omem_responder_if.sv
// Bundles the array OMEM port, the drain control and the result stream of omem_responder.
// slave  : the responder's view of the bus.
// master : the view of the array and host side that drives the bus.
interface omem_responder_if;
    logic        EN_O;
    logic        RW_O;
    logic [3:0]  ADDR_O;
    logic [63:0] WDATA_O;
    logic [63:0] RDATA_O;
    logic        CLR;
    logic        DRAIN_START;
    logic [4:0]  DRAIN_CNT;
    logic        DOUT_VALID;
    logic        DOUT_READY;
    logic [63:0] DOUT_DATA;
    logic [3:0]  DOUT_ADDR;
    logic        DOUT_LAST;
    logic        BUSY;
    logic        DONE;
    logic [15:0] WR_MASK;

    modport slave (
        input  EN_O, RW_O, ADDR_O, WDATA_O, CLR, DRAIN_START, DRAIN_CNT, DOUT_READY,
        output RDATA_O, DOUT_VALID, DOUT_DATA, DOUT_ADDR, DOUT_LAST, BUSY, DONE, WR_MASK
    );

    modport master (
        output EN_O, RW_O, ADDR_O, WDATA_O, CLR, DRAIN_START, DRAIN_CNT, DOUT_READY,
        input  RDATA_O, DOUT_VALID, DOUT_DATA, DOUT_ADDR, DOUT_LAST, BUSY, DONE, WR_MASK
    );
endinterface

// File: rtl/omem_responder.sv
// Output-memory responder: a 16 x 64-bit result store serving the MAC array's OMEM
// port with a one-cycle registered read, plus a drain engine that streams entries
// 0..cnt-1 over valid/ready. The drain reads the store with a write bypass, so a
// beat loaded on the same edge as an array write to that entry carries the new data.
module omem_responder (
    input  logic             CLK,
    input  logic             RST,
    omem_responder_if.slave  bus
);
    localparam int DEPTH = 16;
    localparam int DW    = 64;

    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0] r_mask;
    logic [DW-1:0]   r_rdata;
    logic [DW-1:0]   r_dout_data;
    logic [3:0]      r_dout_addr;
    logic [3:0]      r_idx;
    logic [4:0]      r_cnt;
    logic            r_valid;
    logic            r_last;
    logic            r_done;

    logic            w_wr;
    logic            w_rd;
    logic [4:0]      w_cnt_clamp;
    logic            w_accept;
    logic            w_final;
    logic            w_load;
    logic [3:0]      w_load_addr;
    logic [DW-1:0]   w_load_data;
    logic            w_latch;
    logic [3:0]      w_idx_nxt;
    logic            w_valid_nxt;
    logic            w_last_nxt;
    logic            w_done_nxt;

    assign w_wr        = bus.EN_O & bus.RW_O;
    assign w_rd        = bus.EN_O & ~bus.RW_O;
    assign w_cnt_clamp = (bus.DRAIN_CNT > 5'd16) ? 5'd16 : bus.DRAIN_CNT;
    assign w_accept    = r_valid & bus.DOUT_READY;
    // cnt is 1..16 while sending, so cnt-1 never wraps here
    assign w_final     = ({1'b0, r_idx} == (r_cnt - 5'd1));
    assign w_load_data = (w_wr && (bus.ADDR_O == w_load_addr)) ? bus.WDATA_O : r_mem[w_load_addr];

    // Store and written-entry mask; an array write beats a simultaneous CLR for its own entry
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int a = 0; a < DEPTH; a++) r_mem[a] <= '0;
            r_mask <= '0;
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (w_wr && (bus.ADDR_O == 4'(a))) begin
                    r_mem[a]  <= bus.WDATA_O;
                    r_mask[a] <= 1'b1;
                end else if (bus.CLR) begin
                    r_mem[a]  <= '0;
                    r_mask[a] <= 1'b0;
                end
            end
        end
    end

    // Array read port: registered, samples the store before any same-edge write or CLR
    always_ff @(posedge CLK) begin
        if (RST)       r_rdata <= '0;
        else if (w_rd) r_rdata <= r_mem[bus.ADDR_O];
    end

    // Drain FSM state register
    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Drain FSM next-state: a zero-length drain never leaves IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.DRAIN_START && (w_cnt_clamp != 5'd0)) w_state_nxt = S_SEND;
            S_SEND: if (w_accept && w_final)                      w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Drain FSM outputs: decide which entry to load next and the next stream flags
    always_comb begin
        w_load      = 1'b0;
        w_load_addr = r_idx;
        w_latch     = 1'b0;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.DRAIN_START) begin
                    if (w_cnt_clamp == 5'd0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_latch     = 1'b1;
                        w_load      = 1'b1;
                        w_load_addr = 4'd0;
                        w_idx_nxt   = 4'd0;
                        w_valid_nxt = 1'b1;
                        w_last_nxt  = (w_cnt_clamp == 5'd1);
                    end
                end
            end
            S_SEND: begin
                if (w_accept) begin
                    if (w_final) begin
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt   = r_idx + 4'd1;
                        w_load      = 1'b1;
                        w_load_addr = r_idx + 4'd1;
                        w_last_nxt  = (({1'b0, r_idx} + 5'd2) == r_cnt);
                    end
                end
            end
            default: ;
        endcase
    end

    // Stream registers: beat data/address change only when a new entry is loaded
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_dout_data <= '0;
            r_dout_addr <= '0;
        end else begin
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_done  <= w_done_nxt;
            if (w_latch) r_cnt <= w_cnt_clamp;
            if (w_load) begin
                r_dout_data <= w_load_data;
                r_dout_addr <= w_load_addr;
            end
        end
    end

    assign bus.RDATA_O    = r_rdata;
    assign bus.DOUT_VALID = r_valid;
    assign bus.DOUT_DATA  = r_dout_data;
    assign bus.DOUT_ADDR  = r_dout_addr;
    assign bus.DOUT_LAST  = r_last;
    assign bus.BUSY       = (r_state == S_SEND);
    assign bus.DONE       = r_done;
    assign bus.WR_MASK    = r_mask;
endmodule

// File: tb/tb_omem_responder.sv
// Self-checking bench for omem_responder: randomized array traffic and drains checked
// against a behavioural model of the store (array of entries + mask) and of the stream.
module tb_omem_responder;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    omem_responder_if bus();

    omem_responder dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [63:0] m_mem [16];
    logic [15:0] m_mask;
    logic [63:0] m_rdata;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Update the model with the inputs currently driven, then let the edge happen
    task automatic tick();
        if (RST) begin
            for (int i = 0; i < 16; i++) m_mem[i] = '0;
            m_mask  = '0;
            m_rdata = '0;
        end else begin
            if (bus.EN_O && !bus.RW_O) m_rdata = m_mem[bus.ADDR_O];
            if (bus.CLR) begin
                for (int i = 0; i < 16; i++) m_mem[i] = '0;
                m_mask = '0;
            end
            if (bus.EN_O && bus.RW_O) begin
                m_mem[bus.ADDR_O]  = bus.WDATA_O;
                m_mask[bus.ADDR_O] = 1'b1;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic check_port(input string tag);
        check_val({tag, "/rdata"}, bus.RDATA_O, m_rdata);
        check_val({tag, "/mask"}, {48'd0, bus.WR_MASK}, {48'd0, m_mask});
    endtask

    task automatic port_idle();
        bus.EN_O    = 1'b0;
        bus.RW_O    = 1'b0;
        bus.ADDR_O  = 4'd0;
        bus.WDATA_O = '0;
        bus.CLR     = 1'b0;
    endtask

    task automatic write_entry(input int a, input logic [63:0] d);
        bus.EN_O = 1'b1; bus.RW_O = 1'b1; bus.ADDR_O = a[3:0]; bus.WDATA_O = d;
        tick();
        port_idle();
        check_port("wr");
    endtask

    task automatic read_entry(input int a);
        bus.EN_O = 1'b1; bus.RW_O = 1'b0; bus.ADDR_O = a[3:0];
        tick();
        port_idle();
        check_val("rd", bus.RDATA_O, m_rdata);
    endtask

    // Run one drain of cnt entries. rmode: 0 ready high, 1 pattern 1,0,0,1, 2 random.
    // traffic: random array reads/writes and ignored DRAIN_START during SEND.
    // byp: entry that receives a 64'hDEAD write on the edge it is loaded (-1 none).
    // Returns right after the DONE cycle begins, so a new drain can start in it.
    task automatic drain(input int cnt, input int rmode, input bit traffic, input int byp);
        int n;
        int k;
        int cyc;
        int pidx;
        int pat [4];
        logic rdy;
        logic [63:0] exp_beat;
        pat = '{1, 0, 0, 1};
        n = (cnt > 16) ? 16 : cnt;
        k = 0; cyc = 0; pidx = 0;
        port_idle();
        if (byp == 0 && n > 0) begin
            bus.EN_O = 1'b1; bus.RW_O = 1'b1; bus.ADDR_O = 4'd0; bus.WDATA_O = 64'hDEAD;
        end
        bus.DRAIN_START = 1'b1;
        bus.DRAIN_CNT   = cnt[4:0];
        tick();
        port_idle();
        bus.DRAIN_START = 1'b0;
        if (n == 0) begin
            check_val("zero/done", {63'd0, bus.DONE}, 64'd1);
            check_val("zero/valid", {63'd0, bus.DOUT_VALID}, 64'd0);
            check_val("zero/busy", {63'd0, bus.BUSY}, 64'd0);
            return;
        end
        exp_beat = m_mem[0];
        while (k < n && cyc < 200) begin
            check_val("beat/valid", {63'd0, bus.DOUT_VALID}, 64'd1);
            check_val("beat/busy", {63'd0, bus.BUSY}, 64'd1);
            check_val("beat/done", {63'd0, bus.DONE}, 64'd0);
            check_val("beat/addr", {60'd0, bus.DOUT_ADDR}, 64'(k));
            check_val("beat/data", bus.DOUT_DATA, exp_beat);
            check_val("beat/last", {63'd0, bus.DOUT_LAST}, (k == n - 1) ? 64'd1 : 64'd0);
            if (k == byp) check_val("bypass/dead", bus.DOUT_DATA, 64'hDEAD);
            check_port("beat");
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = pat[pidx % 4] != 0;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            pidx++;
            bus.DOUT_READY = rdy;
            port_idle();
            bus.DRAIN_START = 1'b0;
            if (traffic) begin
                bus.EN_O        = 1'($urandom_range(0, 1));
                bus.RW_O        = 1'($urandom_range(0, 1));
                bus.ADDR_O      = 4'($urandom_range(0, 15));
                bus.WDATA_O     = {$urandom, $urandom};
                bus.DRAIN_START = 1'($urandom_range(0, 1));
                bus.DRAIN_CNT   = 5'($urandom_range(0, 31));
            end
            if (rdy && (k + 1 < n) && (byp == k + 1)) begin
                bus.EN_O = 1'b1; bus.RW_O = 1'b1; bus.ADDR_O = byp[3:0]; bus.WDATA_O = 64'hDEAD;
            end
            tick();
            cyc++;
            if (rdy) begin
                k++;
                if (k < n) exp_beat = m_mem[k];
            end
        end
        port_idle();
        bus.DRAIN_START = 1'b0;
        bus.DOUT_READY  = 1'b0;
        check_val("drain/beats", 64'(k), 64'(n));
        check_val("end/valid", {63'd0, bus.DOUT_VALID}, 64'd0);
        check_val("end/last", {63'd0, bus.DOUT_LAST}, 64'd0);
        check_val("end/busy", {63'd0, bus.BUSY}, 64'd0);
        check_val("end/done", {63'd0, bus.DONE}, 64'd1);
    endtask

    task automatic settle();
        port_idle();
        bus.DRAIN_START = 1'b0;
        tick();
        check_val("settle/done", {63'd0, bus.DONE}, 64'd0);
        check_val("settle/valid", {63'd0, bus.DOUT_VALID}, 64'd0);
        check_val("settle/busy", {63'd0, bus.BUSY}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        port_idle();
        bus.DRAIN_START = 1'b0;
        bus.DRAIN_CNT   = 5'd0;
        bus.DOUT_READY  = 1'b0;
        RST = 1'b1;
        tick();
        tick();
        check_val("rst/rdata", bus.RDATA_O, 64'd0);
        check_val("rst/mask", {48'd0, bus.WR_MASK}, 64'd0);
        check_val("rst/valid", {63'd0, bus.DOUT_VALID}, 64'd0);
        check_val("rst/busy", {63'd0, bus.BUSY}, 64'd0);
        check_val("rst/done", {63'd0, bus.DONE}, 64'd0);
        check_val("rst/ddata", bus.DOUT_DATA, 64'd0);
        RST = 1'b0;

        // Basic write then read
        write_entry(3, 64'h1111);
        read_entry(3);
        check_val("t1/rdata", bus.RDATA_O, 64'h1111);
        check_val("t1/mask", {48'd0, bus.WR_MASK}, 64'h0008);

        // Random array traffic with occasional CLR
        for (int c = 0; c < 300; c++) begin
            bus.EN_O    = 1'($urandom_range(0, 1));
            bus.RW_O    = 1'($urandom_range(0, 1));
            bus.ADDR_O  = 4'($urandom_range(0, 15));
            bus.WDATA_O = {$urandom, $urandom};
            bus.CLR     = ($urandom_range(0, 19) == 0);
            tick();
            check_port("rand");
        end
        port_idle();

        // Full drain at full rate
        for (int a = 0; a < 16; a++) write_entry(a, 64'h100 + 64'(a));
        drain(16, 0, 1'b0, -1);
        settle();

        // Stalling consumer, then a clamped drain started in the DONE cycle
        drain(4, 1, 1'b0, -1);
        drain(20, 2, 1'b1, -1);
        settle();

        // Write bypass into the entry being loaded
        drain(4, 0, 1'b0, 2);
        settle();
        drain(3, 2, 1'b0, 0);
        settle();

        // Zero-length drain
        drain(0, 0, 1'b0, -1);
        settle();

        // Random drains with concurrent array traffic
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 16; a++) write_entry(a, {$urandom, $urandom});
            drain(int'($urandom_range(0, 20)), 2, 1'b1, -1);
            settle();
        end

        // CLR racing a write
        for (int a = 0; a < 16; a++) write_entry(a, 64'hABC0 + 64'(a));
        bus.CLR = 1'b1; bus.EN_O = 1'b1; bus.RW_O = 1'b1; bus.ADDR_O = 4'd2; bus.WDATA_O = 64'h5;
        tick();
        port_idle();
        check_val("clr/mask", {48'd0, bus.WR_MASK}, 64'h0004);
        for (int a = 0; a < 16; a++) begin
            read_entry(a);
            check_val("clr/entry", bus.RDATA_O, (a == 2) ? 64'h5 : 64'h0);
        end

        // Reset in the middle of a drain
        for (int a = 0; a < 16; a++) write_entry(a, 64'h7700 + 64'(a));
        bus.DRAIN_START = 1'b1; bus.DRAIN_CNT = 5'd8;
        tick();
        bus.DRAIN_START = 1'b0; bus.DOUT_READY = 1'b1;
        tick();
        tick();
        check_val("mid/busy", {63'd0, bus.BUSY}, 64'd1);
        RST = 1'b1;
        tick();
        check_val("rstmid/valid", {63'd0, bus.DOUT_VALID}, 64'd0);
        check_val("rstmid/busy", {63'd0, bus.BUSY}, 64'd0);
        check_val("rstmid/done", {63'd0, bus.DONE}, 64'd0);
        RST = 1'b0;
        bus.DOUT_READY = 1'b0;
        tick();
        check_val("rstmid/done2", {63'd0, bus.DONE}, 64'd0);
        check_val("rstmid/mask", {48'd0, bus.WR_MASK}, 64'd0);
        for (int a = 0; a < 16; a++) begin
            read_entry(a);
            check_val("rstmid/entry", bus.RDATA_O, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
